write_address_generator_filter: RTL and testbench
=================================================

WRITE_ADDRESS_GENERATOR_FILTER -- requirements
Module: write_address_generator_filter

Interface
REQ-001 Parameter SP_SIZE, default 8, width of filter scratchpad base/offset register.
REQ-002 Parameter FILTER_SIZE_REG_SIZE, default 8, width of filter_size and in-filter counter.
REQ-003 Parameter POINTER_SIZE, default 8, width of write_pointer.
REQ-004 Parameter NUM_FILTERS, default 4, number of filter slots in scratchpad.
REQ-005 Parameter CNT_SIZE, default 3, width of filters_stored; SHALL hold value NUM_FILTERS.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-008 start  input  1  one-cycle pulse: latch filter_size, begin accepting words.
REQ-009 filter_size  input  FILTER_SIZE_REG_SIZE  words per filter, sampled only on accepted start.
REQ-010 in_valid  input  1  producer has a filter word this cycle.
REQ-011 in_ready  output  1  block can accept a word this cycle.
REQ-012 wen  output  1  scratchpad write enable.
REQ-013 write_pointer  output  POINTER_SIZE  scratchpad write address.
REQ-014 release_filter  input  1  one-cycle pulse from read side: one stored filter consumed.
REQ-015 filter_done  output  1  one-cycle pulse: a complete filter was written.
REQ-016 filters_stored  output  CNT_SIZE  complete filters held, unread.
REQ-017 full  output  1  filters_stored == NUM_FILTERS.
REQ-018 empty  output  1  filters_stored == 0.

Function
REQ-019 FSM states SHALL be IDLE, FILL, FULL.
REQ-020 IDLE: start with filter_size != 0 -> FILL, size_q <= filter_size; start with filter_size == 0 SHALL be ignored (stay IDLE).
REQ-021 start in FILL or FULL SHALL be ignored; size_q unchanged.
REQ-022 in_ready SHALL be 1 only in FILL, combinational from state.
REQ-023 wen SHALL equal in_valid & in_ready, same cycle (zero latency).
REQ-024 write_pointer SHALL equal base + point_in_filter, truncated to POINTER_SIZE, combinational.
REQ-025 Each wen SHALL increment point_in_filter; when point_in_filter == size_q-1 on wen, point_in_filter <= 0 and filter completes.
REQ-026 On filter completion base SHALL advance by size_q, except when slot index == NUM_FILTERS-1, then base <= 0 and slot <= 0; otherwise slot <= slot+1.
REQ-027 filter_done SHALL be registered, high exactly the cycle after the completing write.
REQ-028 filters_stored: +1 on completion, -1 on release_filter, unchanged when both occur in the same cycle.
REQ-029 release_filter while filters_stored == 0 (and no same-cycle completion) SHALL be ignored.
REQ-030 FILL -> FULL on the cycle a completion makes filters_stored == NUM_FILTERS.
REQ-031 FULL -> FILL on release_filter; in_ready high the following cycle, write_pointer = current base.
REQ-032 Block SHALL never return to IDLE except via reset.
REQ-033 Words while in_ready == 0 SHALL not be written; producer holds in_valid (no data loss in block).

Reset
REQ-034 rst low SHALL immediately clear state to IDLE, base, slot, point_in_filter, size_q, filters_stored to 0, independent of clk.
REQ-035 During and after reset: in_ready=0, wen=0, write_pointer=0, filter_done=0, filters_stored=0, full=0, empty=1.
REQ-036 Reset asserted mid-filter SHALL discard the partial filter; no filter_done generated.

Verification
REQ-037 rst=0 pulse, no clk edge -> all outputs at REQ-035 values immediately.
REQ-038 start, filter_size=3; 3 words back-to-back -> write_pointer 0,1,2 with wen=1; filter_done=1 next cycle; filters_stored=1, empty=0.
REQ-039 size 3, 12 words continuous -> pointers 0..11; full=1, in_ready=0 after 12th; 13th word stalls; release_filter -> in_ready=1 next cycle, pointer 0 (wrap), filters_stored=3.
REQ-040 filters_stored=2, last word of filter coincides with release_filter -> filter_done=1, filters_stored stays 2.
REQ-041 release_filter at empty -> filters_stored stays 0; start with filter_size=0 -> stays IDLE, in_ready=0; second start with size 5 during FILL -> size_q stays 3.
REQ-042 size 3, after 2 words of first filter assert rst -> pointer 0, in_ready=0, no filter_done; new start size 3 -> pointers restart at 0.

Source files
------------

// File: rtl/write_address_generator_filter.sv
// Write-side address generator for a filter scratchpad: accepts filter words into a ring of
// NUM_FILTERS slots and tracks how many complete filters are waiting for the read side.
module write_address_generator_filter #(
    parameter int SP_SIZE              = 8,
    parameter int FILTER_SIZE_REG_SIZE = 8,
    parameter int POINTER_SIZE         = 8,
    parameter int NUM_FILTERS          = 4,
    parameter int CNT_SIZE             = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            wen,
    output logic [POINTER_SIZE-1:0]         write_pointer,
    input  logic                            release_filter,
    output logic                            filter_done,
    output logic [CNT_SIZE-1:0]             filters_stored,
    output logic                            full,
    output logic                            empty
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    localparam int SUM_W = ((SP_SIZE > FILTER_SIZE_REG_SIZE) ? SP_SIZE : FILTER_SIZE_REG_SIZE) + 1;

    logic [1:0]                      state_q, state_d;
    logic [SP_SIZE-1:0]              base_q, base_d;
    logic [CNT_SIZE-1:0]             slot_q, slot_d;
    logic [FILTER_SIZE_REG_SIZE-1:0] pif_q, pif_d;
    logic [FILTER_SIZE_REG_SIZE-1:0] size_q, size_d;
    logic [CNT_SIZE-1:0]             cnt_q, cnt_d;
    logic                            done_q;

    logic             complete;
    logic [SUM_W-1:0] ptr_sum;

    assign in_ready       = (state_q == FILL);
    assign wen            = in_valid & in_ready;
    assign ptr_sum        = SUM_W'(base_q) + SUM_W'(pif_q);
    assign write_pointer  = POINTER_SIZE'(ptr_sum);
    assign filter_done    = done_q;
    assign filters_stored = cnt_q;
    assign full           = (cnt_q == CNT_SIZE'(NUM_FILTERS));
    assign empty          = (cnt_q == '0);

    // size_q is never zero while filling, so size_q-1 cannot underflow here
    assign complete = wen && (pif_q == size_q - FILTER_SIZE_REG_SIZE'(1));

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        slot_d  = slot_q;
        pif_d   = pif_q;
        size_d  = size_q;
        cnt_d   = cnt_q;

        if (complete) begin
            pif_d = '0;
            if (slot_q == CNT_SIZE'(NUM_FILTERS - 1)) begin
                base_d = '0;
                slot_d = '0;
            end else begin
                base_d = base_q + SP_SIZE'(size_q);
                slot_d = slot_q + CNT_SIZE'(1);
            end
        end else if (wen) begin
            pif_d = pif_q + FILTER_SIZE_REG_SIZE'(1);
        end

        // A release that coincides with a completion cancels it; a release with nothing stored is dropped
        if (complete && !release_filter) begin
            cnt_d = cnt_q + CNT_SIZE'(1);
        end else if (release_filter && !complete && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_SIZE'(1);
        end

        case (state_q)
            IDLE: begin
                if (start && (filter_size != '0)) begin
                    state_d = FILL;
                    size_d  = filter_size;
                end
            end
            FILL: begin
                if (complete && (cnt_d == CNT_SIZE'(NUM_FILTERS))) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (release_filter) begin
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            slot_q  <= '0;
            pif_q   <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            slot_q  <= slot_d;
            pif_q   <= pif_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            done_q  <= complete;
        end
    end

endmodule

// File: tb/tb_write_address_generator_filter.sv
// Randomized bench for write_address_generator_filter with a behavioural ring-buffer model
// and a few directed scenarios pinned to literal values.
module tb_write_address_generator_filter;

    localparam int SP  = 8;
    localparam int FSW = 8;
    localparam int PW  = 8;
    localparam int NF  = 4;
    localparam int CW  = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [FSW-1:0] filter_size = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           wen;
    logic [PW-1:0]  write_pointer;
    logic           release_filter = 1'b0;
    logic           filter_done;
    logic [CW-1:0]  filters_stored;
    logic           full;
    logic           empty;

    write_address_generator_filter #(
        .SP_SIZE(SP), .FILTER_SIZE_REG_SIZE(FSW), .POINTER_SIZE(PW),
        .NUM_FILTERS(NF), .CNT_SIZE(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .filter_size(filter_size),
        .in_valid(in_valid), .in_ready(in_ready), .wen(wen),
        .write_pointer(write_pointer), .release_filter(release_filter),
        .filter_done(filter_done), .filters_stored(filters_stored),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    // Model: a ring of NF slots of `m_size` words each; `m_fidx` is the slot being filled
    int m_started, m_size, m_word, m_fidx, m_stored, m_done;

    int obs_ptr, obs_wen, obs_ready, obs_done, obs_cnt, obs_full, obs_empty;

    task automatic check(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_started = 0; m_size = 0; m_word = 0; m_fidx = 0; m_stored = 0; m_done = 0;
    endtask

    task automatic cycle(input int s, input int fs, input int v, input int r);
        int e_ready, e_wen, e_ptr, c, r_eff;
        @(negedge clk);
        start = s[0]; filter_size = FSW'(fs); in_valid = v[0]; release_filter = r[0];
        #1;
        obs_ptr = int'(write_pointer); obs_wen = int'(wen); obs_ready = int'(in_ready);
        obs_done = int'(filter_done); obs_cnt = int'(filters_stored);
        obs_full = int'(full); obs_empty = int'(empty);

        e_ready = (m_started != 0 && m_stored < NF) ? 1 : 0;
        e_wen   = (v != 0 && e_ready != 0) ? 1 : 0;
        e_ptr   = (((m_fidx * m_size) % (1 << SP)) + m_word) % (1 << PW);
        check("in_ready", obs_ready, e_ready);
        check("wen", obs_wen, e_wen);
        check("write_pointer", obs_ptr, e_ptr);
        check("filter_done", obs_done, m_done);
        check("filters_stored", obs_cnt, m_stored);
        check("full", obs_full, (m_stored == NF) ? 1 : 0);
        check("empty", obs_empty, (m_stored == 0) ? 1 : 0);

        c = (e_wen != 0 && m_word == m_size - 1) ? 1 : 0;
        r_eff = (r != 0 && (m_stored > 0 || c != 0)) ? 1 : 0;
        @(posedge clk);
        if (m_started == 0 && s != 0 && fs != 0) begin
            m_started = 1;
            m_size = fs;
        end
        if (c != 0) begin
            m_word = 0;
            m_fidx = (m_fidx + 1) % NF;
        end else if (e_wen != 0) begin
            m_word++;
        end
        m_stored = m_stored + c - r_eff;
        m_done = c;
    endtask

    // Asserts reset between clock edges and checks outputs before any edge arrives
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_wen", int'(wen), 0);
        check("rst_pointer", int'(write_pointer), 0);
        check("rst_done", int'(filter_done), 0);
        check("rst_stored", int'(filters_stored), 0);
        check("rst_full", int'(full), 0);
        check("rst_empty", int'(empty), 1);
        model_reset();
        start = 1'b0; in_valid = 1'b0; release_filter = 1'b0; filter_size = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check("init_ready", int'(in_ready), 0);
        check("init_pointer", int'(write_pointer), 0);
        check("init_empty", int'(empty), 1);
        @(negedge clk);
        rst = 1'b1;

        // Single filter of 3 words
        cycle(1, 3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 0);
            check("f3_ptr", obs_ptr, i);
            check("f3_wen", obs_wen, 1);
        end
        cycle(0, 0, 0, 0);
        check("f3_done", obs_done, 1);
        check("f3_stored", obs_cnt, 1);
        check("f3_empty", obs_empty, 0);

        // Fill all four slots, stall, release and wrap
        do_reset();
        cycle(1, 3, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cycle(0, 0, 1, 0);
            check("fill_ptr", obs_ptr, i);
        end
        cycle(0, 0, 1, 0);
        check("full_flag", obs_full, 1);
        check("full_ready", obs_ready, 0);
        check("full_stall_wen", obs_wen, 0);
        cycle(0, 0, 1, 1);
        check("rel_wen", obs_wen, 0);
        cycle(0, 0, 1, 0);
        check("wrap_ready", obs_ready, 1);
        check("wrap_ptr", obs_ptr, 0);
        check("wrap_stored", obs_cnt, 3);

        // Completion coinciding with a release
        do_reset();
        cycle(1, 3, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0);
        check("coin_pre_stored", obs_cnt, 2);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 1);
        check("coin_last_ptr", obs_ptr, 8);
        cycle(0, 0, 0, 0);
        check("coin_done", obs_done, 1);
        check("coin_stored", obs_cnt, 2);

        // Ignored release, zero-size start, restart during fill
        do_reset();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        check("empty_rel_stored", obs_cnt, 0);
        cycle(1, 0, 1, 0);
        cycle(0, 0, 1, 0);
        check("zero_start_ready", obs_ready, 0);
        cycle(1, 3, 0, 0);
        cycle(1, 5, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        check("restart_done", obs_done, 1);
        check("restart_base", obs_ptr, 3);

        // Reset in the middle of a filter
        do_reset();
        cycle(1, 3, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        check("mid_ptr_before", obs_ptr, 1);
        do_reset();
        cycle(0, 0, 0, 0);
        check("mid_no_done", obs_done, 0);
        cycle(1, 3, 0, 0);
        cycle(0, 0, 1, 0);
        check("mid_restart_ptr", obs_ptr, 0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle(($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 6)),
                  ($urandom_range(0, 9) < 7) ? 1 : 0, ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
